key_shift_register: RTL and testbench
=====================================

// Module: key_shift_register
// PURPOSE
//  Parametrised LED shift/rotate register driven by four pushbuttons on the DE2-115 board.
//  Each KEY has its own synchroniser and counter-based debouncer.
//  A clean press pulse drives one action:
//    KEY[0] toggles the serial-in bit, KEY[1] steps, KEY[2] toggles direction, KEY[3] cycles mode.
//  Auto modes step on an internal timer. Top-level demo block driving LEDR/LEDG directly.
// PARAMETERS
//  WIDTH           8          register width; >=2
//  RESET_PATTERN   'h1        LEDR value on reset (WIDTH bits)
//  SYNC_STAGES     2          synchroniser flops per KEY; >=2
//  DEBOUNCE_CYCLES 500000     stable cycles required before accepting a KEY change (10 ms @ 50 MHz); >=2
//  AUTO_PERIOD     25000000   cycles between automatic steps (0.5 s @ 50 MHz); >=2
// PORTS
//  CLOCK_50  in   1      system clock
//  RESET     in   1      synchronous, active-high reset
//  KEY       in   4      raw pushbuttons, active-low (0 = pressed), asynchronous
//  LEDR      out  WIDTH  shift register contents
//  LEDG      out  4      [0] serial-in bit, [1] direction (0=left, 1=right), [3:2] mode
// BEHAVIOUR
//  Reset (RESET=1 at an edge):
//    LEDR=RESET_PATTERN; LEDG=0; serial-in=0, dir=0, mode=00.
//    Debounced KEY state=1111 (released); debounce counters=0; auto timer=0. Sync flops -> 1.
//  Debounce, per KEY:
//    - Each cycle that sync output != stable: counter increments.
//    - When counter==DEBOUNCE_CYCLES-1 and sync output still differs: stable<=sync, counter<=0.
//    - Any cycle with sync output == stable: counter<=0.
//    - Glitch shorter than DEBOUNCE_CYCLES: ignored.
//  Press pulse: 1-cycle strobe on stable 1->0 only.
//    - Release (0->1) produces no action.
//    - A held key produces exactly one pulse.
//  Latency: KEY sampled low at edge E -> stable falls at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1
//    -> pulse high the following cycle -> action registered at the next edge.
//  Step, with b = serial-in bit and r = LEDR:
//    mode 00 manual shift / 10 auto shift:   left r<={r[W-2:0],b}; right r<={b,r[W-1:1]}
//    mode 01 manual rotate / 11 auto rotate: left r<={r[W-2:0],r[W-1]}; right r<={r[0],r[W-1:1]}
//  Mode FSM: a KEY[3] pulse advances 00->01->10->11->00. Every mode change clears the auto timer.
//  Auto timer (modes 10/11):
//    - Counts 0..AUTO_PERIOD-1; a step occurs on the wrap cycle.
//    - A KEY[1] pulse in an auto mode steps immediately and clears the timer.
//    - Timer is held at 0 in modes 00/01.
//  Simultaneous events in one cycle: all pulses are honoured.
//    - A step uses the pre-update b, dir and mode (registered values).
//    - Auto wrap + KEY[1] pulse = exactly one step.
//    - KEY[3] pulse + step trigger: step executes in the old mode; timer cleared.
//  Reset mid-operation:
//    - All state returns to reset values at that edge; in-flight debounce counts are discarded.
//    - A key still held after reset is seen as a new press after the full debounce latency.
// TESTING (sim params: WIDTH=8, DEBOUNCE_CYCLES=4, AUTO_PERIOD=10, SYNC_STAGES=2)
//  1. Pulse RESET 1 cycle -> LEDR=8'h01, LEDG=4'h0; KEY all 1 for 50 cycles -> no change.
//  2. KEY[1] low 3 cycles then high -> LEDR stays 8'h01.
//     KEY[1] held low 20 cycles -> LEDR=8'h02 exactly once, 6 edges after first low sample.
//     Release -> no change.
//  3. KEY[0] press, then KEY[1] press -> LEDG[0]=1, LEDR 8'h01->8'h03.
//     KEY[0]+KEY[1] pressed together from reset -> LEDR=8'h02 (old b=0), LEDG[0]=1.
//  4. KEY[3] x1 (mode 01), KEY[2] x1 (right) -> LEDG=4'h6.
//     KEY[1] press -> LEDR 8'h01->8'h80; second press -> 8'h40.
//  5. KEY[3] x2 (mode 10, left, b=0) -> LEDR steps 01,02,04,... every 10 cycles.
//     KEY[1] 3 cycles into a period -> immediate step; next auto step 10 cycles later.
//  6. RESET during mode 11 with KEY[1] held -> next edge LEDR=8'h01, LEDG=0.
//     Held KEY[1] -> one manual shift 6 edges after reset deasserts.

Source files
------------

// File: rtl/key_shift_register.sv
// LED shift/rotate register driven by four debounced pushbuttons.
// Each key press triggers one action; the auto modes step on an internal timer.
module key_shift_register #(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] RESET_PATTERN   = 'h1,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               AUTO_PERIOD     = 25000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [3:0]       KEY,
  output logic [WIDTH-1:0] LEDR,
  output logic [3:0]       LEDG
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_MAN_SHIFT   = 2'b00,
    MODE_MAN_ROTATE  = 2'b01,
    MODE_AUTO_SHIFT  = 2'b10,
    MODE_AUTO_ROTATE = 2'b11
  } mode_e;

  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [DW-1:0]          deb_cnt [4];
  logic [3:0]             key_sync;
  logic [3:0]             key_stable;
  logic [3:0]             key_stable_d;
  logic [3:0]             press;

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             serial_in_q, dir_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic             auto_mode, wrap, step, in_bit;

  always_comb begin
    key_sync = '0;
    for (int k = 0; k < 4; k++) begin
      key_sync[k] = sync_q[k][SYNC_STAGES-1];
    end
  end

  // A key's stable level flips only after the synchronised input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int k = 0; k < 4; k++) begin
        sync_q[k]  <= '1;
        deb_cnt[k] <= '0;
      end
      key_stable   <= '1;
      key_stable_d <= '1;
    end else begin
      key_stable_d <= key_stable;
      for (int k = 0; k < 4; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], KEY[k]};
        if (key_sync[k] == key_stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          key_stable[k] <= key_sync[k];
          deb_cnt[k]    <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Press strobe: stable level fell (active-low keys); releases are ignored.
  assign press = key_stable_d & ~key_stable;

  always_comb begin
    mode_d = mode_q;
    if (press[3]) begin
      case (mode_q)
        MODE_MAN_SHIFT:   mode_d = MODE_MAN_ROTATE;
        MODE_MAN_ROTATE:  mode_d = MODE_AUTO_SHIFT;
        MODE_AUTO_SHIFT:  mode_d = MODE_AUTO_ROTATE;
        MODE_AUTO_ROTATE: mode_d = MODE_MAN_SHIFT;
        default:          mode_d = MODE_MAN_SHIFT;
      endcase
    end
  end

  // A step always uses the registered mode/dir/serial-in, so simultaneous
  // key pulses take effect only from the following cycle.
  always_comb begin
    auto_mode = mode_q[1];
    wrap      = auto_mode && (timer_q == TIMER_LAST);
    step      = press[1] || wrap;
    in_bit    = mode_q[0] ? (dir_q ? r_q[0] : r_q[WIDTH-1]) : serial_in_q;
    r_d       = r_q;
    if (step) begin
      r_d = dir_q ? {in_bit, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], in_bit};
    end
    timer_d = timer_q + 1'b1;
    if (!auto_mode || step || press[3]) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mode_q      <= MODE_MAN_SHIFT;
      r_q         <= RESET_PATTERN;
      serial_in_q <= 1'b0;
      dir_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      r_q         <= r_d;
      serial_in_q <= serial_in_q ^ press[0];
      dir_q       <= dir_q ^ press[2];
      timer_q     <= timer_d;
    end
  end

  assign LEDR = r_q;
  assign LEDG = {mode_q, dir_q, serial_in_q};

endmodule

// File: tb/tb_key_shift_register.sv
// Bench for key_shift_register: directed scenarios plus random key activity,
// checked against a time-based model of debounced presses and auto stepping.
module tb_key_shift_register;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int PER   = 10;
  localparam logic [WIDTH-1:0] RST_PAT = 8'h01;

  logic             CLOCK_50 = 1'b0;
  logic             RESET    = 1'b1;
  logic [3:0]       KEY      = 4'hF;
  logic [WIDTH-1:0] LEDR;
  logic [3:0]       LEDG;

  int checks   = 0;
  int failures = 0;

  key_shift_register #(
    .WIDTH(WIDTH), .RESET_PATTERN(RST_PAT), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(PER)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY), .LEDR(LEDR), .LEDG(LEDG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: n is the index of the latest rising edge. A key held low
  // for DEB raw samples is a press whose action lands SYNC+1 edges after the
  // DEB-th low sample; auto steps fall PER edges after the last timer clear.
  int               n = 0;
  logic [WIDTH-1:0] m_r = RST_PAT;
  logic             m_b = 1'b0;
  logic             m_dir = 1'b0;
  logic [1:0]       m_mode = 2'd0;
  int               anchor = 0;
  int               low_run [4];
  int               high_run [4];
  logic [3:0]       m_deb = 4'hF;
  int               act_q[$];
  logic [3:0]       m_g;

  assign m_g = {m_mode, m_dir, m_b};

  always @(posedge CLOCK_50) begin : ref_model
    logic [3:0] hit;
    logic       wrap, step, in_bit, auto_m;
    int         keep[$];
    n = n + 1;
    if (RESET) begin
      m_r = RST_PAT; m_b = 1'b0; m_dir = 1'b0; m_mode = 2'd0;
      anchor = n; act_q.delete(); m_deb = 4'hF;
      for (int k = 0; k < 4; k++) begin
        low_run[k] = 0; high_run[k] = 0;
      end
    end else begin
      hit = 4'h0;
      keep.delete();
      foreach (act_q[i]) begin
        if (act_q[i] / 4 == n) hit[act_q[i] % 4] = 1'b1;
        else keep.push_back(act_q[i]);
      end
      act_q = keep;
      auto_m = m_mode[1];
      wrap   = auto_m && (n - anchor == PER);
      step   = hit[1] || wrap;
      if (step) begin
        if (!m_mode[0]) in_bit = m_b;
        else            in_bit = m_dir ? m_r[0] : m_r[WIDTH-1];
        if (m_dir) m_r = (m_r >> 1) | ({{(WIDTH-1){1'b0}}, in_bit} << (WIDTH-1));
        else       m_r = (m_r << 1) | {{(WIDTH-1){1'b0}}, in_bit};
      end
      if (hit[3] || (auto_m && step)) anchor = n;
      if (hit[0]) m_b = ~m_b;
      if (hit[2]) m_dir = ~m_dir;
      if (hit[3]) m_mode = m_mode + 2'd1;
      for (int k = 0; k < 4; k++) begin
        if (!KEY[k]) begin
          low_run[k] = low_run[k] + 1; high_run[k] = 0;
          if (low_run[k] == DEB && m_deb[k]) begin
            m_deb[k] = 1'b0;
            act_q.push_back((n + SYNC + 1) * 4 + k);
          end
        end else begin
          high_run[k] = high_run[k] + 1; low_run[k] = 0;
          if (high_run[k] == DEB && !m_deb[k]) m_deb[k] = 1'b1;
        end
      end
    end
  end

  // Drivers: inputs change just after a falling edge, outputs are read there too.
  task automatic drive_cycle(input logic [3:0] k);
    KEY = k;
    @(negedge CLOCK_50);
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int idle);
    for (int i = 0; i < hold; i++) drive_cycle(k);
    for (int i = 0; i < idle; i++) drive_cycle(4'hF);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive_cycle(KEY);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    KEY   = 4'hF;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    checks++;
    if (LEDR !== RST_PAT || LEDG !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: LEDR=%h LEDG=%h expected LEDR=%h LEDG=0", LEDR, LEDG, RST_PAT);
    end
    for (int i = 0; i < 50; i++) begin
      drive_cycle(4'hF);
      checks++;
      if (LEDR !== RST_PAT || LEDG !== 4'h0) begin
        failures++;
        $display("FAIL idle_stable: LEDR=%h LEDG=%h expected LEDR=%h LEDG=0", LEDR, LEDG, RST_PAT);
      end
    end
  endtask

  task automatic test_debounce();
    int e0;
    for (int i = 0; i < DEB - 1; i++) drive_cycle(4'hD);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(4'hF);
      checks++;
      if (LEDR !== RST_PAT) begin
        failures++;
        $display("FAIL glitch_ignored: LEDR=%h expected %h", LEDR, RST_PAT);
      end
    end
    e0 = n + 1;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(4'hD);
      checks++;
      if (LEDR !== m_r || LEDG !== m_g) begin
        failures++;
        $display("FAIL hold_track: LEDR=%h LEDG=%h expected LEDR=%h LEDG=%h", LEDR, LEDG, m_r, m_g);
      end
      if (n == e0 + SYNC + DEB - 1) begin
        checks++;
        if (LEDR !== RST_PAT) begin
          failures++;
          $display("FAIL press_not_early: LEDR=%h expected %h", LEDR, RST_PAT);
        end
      end
      if (n == e0 + SYNC + DEB) begin
        checks++;
        if (LEDR !== 8'h02) begin
          failures++;
          $display("FAIL press_latency: LEDR=%h expected 02", LEDR);
        end
      end
    end
    press(4'hF, 0, 20);
    checks++;
    if (LEDR !== 8'h02) begin
      failures++;
      $display("FAIL release_no_action: LEDR=%h expected 02", LEDR);
    end
  endtask

  task automatic test_serial_in();
    do_reset();
    press(4'hE, 8, 12);
    press(4'hD, 8, 12);
    checks++;
    if (LEDR !== 8'h03 || LEDG !== 4'h1) begin
      failures++;
      $display("FAIL serial_in_shift: LEDR=%h LEDG=%h expected LEDR=03 LEDG=1", LEDR, LEDG);
    end
    do_reset();
    press(4'hC, 8, 12);
    checks++;
    if (LEDR !== 8'h02 || LEDG !== 4'h1) begin
      failures++;
      $display("FAIL simultaneous_old_b: LEDR=%h LEDG=%h expected LEDR=02 LEDG=1", LEDR, LEDG);
    end
  endtask

  task automatic test_rotate();
    do_reset();
    press(4'h7, 8, 12);
    press(4'hB, 8, 12);
    checks++;
    if (LEDG !== 4'h6) begin
      failures++;
      $display("FAIL rotate_setup: LEDG=%h expected 6", LEDG);
    end
    press(4'hD, 8, 12);
    checks++;
    if (LEDR !== 8'h80) begin
      failures++;
      $display("FAIL rotate_right_1: LEDR=%h expected 80", LEDR);
    end
    press(4'hD, 8, 12);
    checks++;
    if (LEDR !== 8'h40 || LEDR !== m_r) begin
      failures++;
      $display("FAIL rotate_right_2: LEDR=%h expected 40 (model %h)", LEDR, m_r);
    end
  endtask

  task automatic test_auto();
    int               e2, a2;
    logic [3:0]       k;
    int               off_tab [9] = '{9, 10, 20, 30, 32, 33, 42, 43, 53};
    logic [WIDTH-1:0] val_tab [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h08, 8'h10, 8'h10, 8'h20, 8'h40};
    do_reset();
    press(4'h7, 8, 12);
    e2 = n + 1;
    a2 = e2 + SYNC + DEB;
    for (int i = 0; i < 70; i++) begin
      k = 4'hF;
      if (i < 8) k[3] = 1'b0;
      if (n + 1 >= a2 + 27 && n + 1 < a2 + 35) k[1] = 1'b0;
      drive_cycle(k);
      checks++;
      if (LEDR !== m_r || LEDG !== m_g) begin
        failures++;
        $display("FAIL auto_track: LEDR=%h LEDG=%h expected LEDR=%h LEDG=%h", LEDR, LEDG, m_r, m_g);
      end
      for (int j = 0; j < 9; j++) begin
        if (n - a2 == off_tab[j]) begin
          checks++;
          if (LEDR !== val_tab[j]) begin
            failures++;
            $display("FAIL auto_step_at_%0d: LEDR=%h expected %h", off_tab[j], LEDR, val_tab[j]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int r_edge;
    press(4'h7, 8, 12);
    checks++;
    if (LEDG[3:2] !== 2'b11) begin
      failures++;
      $display("FAIL mode_auto_rotate: LEDG=%h expected mode 11", LEDG);
    end
    for (int i = 0; i < 2; i++) drive_cycle(4'hD);
    do_reset();
    r_edge = n;
    checks++;
    if (LEDR !== RST_PAT || LEDG !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset: LEDR=%h LEDG=%h expected LEDR=%h LEDG=0", LEDR, LEDG, RST_PAT);
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(4'hD);
      checks++;
      if (LEDR !== m_r || LEDG !== m_g) begin
        failures++;
        $display("FAIL held_track: LEDR=%h LEDG=%h expected LEDR=%h LEDG=%h", LEDR, LEDG, m_r, m_g);
      end
      if (n == r_edge + SYNC + DEB) begin
        checks++;
        if (LEDR !== RST_PAT) begin
          failures++;
          $display("FAIL held_not_early: LEDR=%h expected %h", LEDR, RST_PAT);
        end
      end
      if (n == r_edge + SYNC + DEB + 1) begin
        checks++;
        if (LEDR !== 8'h02) begin
          failures++;
          $display("FAIL held_after_reset: LEDR=%h expected 02", LEDR);
        end
      end
    end
    press(4'hF, 0, 20);
    checks++;
    if (LEDR !== 8'h02 || LEDG !== 4'h0) begin
      failures++;
      $display("FAIL held_single_step: LEDR=%h LEDG=%h expected LEDR=02 LEDG=0", LEDR, LEDG);
    end
  endtask

  task automatic test_random();
    logic [3:0] k;
    int         hold, idle;
    do_reset();
    for (int s = 0; s < 60; s++) begin
      k    = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 9));
      idle = int'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) RESET = 1'b1;
      for (int i = 0; i < hold + idle; i++) begin
        drive_cycle(i < hold ? k : 4'hF);
        RESET = 1'b0;
        checks++;
        if (LEDR !== m_r || LEDG !== m_g) begin
          failures++;
          $display("FAIL random_track: edge=%0d LEDR=%h LEDG=%h expected LEDR=%h LEDG=%h",
                   n, LEDR, LEDG, m_r, m_g);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_serial_in();
    test_rotate();
    test_auto();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
